// File: rtl/point_compress.sv
// -----------------------------------------------------------------------------
// point_compress
//
// Converts an Ed25519 point in extended coordinates (X:Y:Z:T) into the standard
// 256-bit compressed encoding enc = {x[0], y}. Here x = X/Z mod p, y = Y/Z mod p
// and p = 2^255-19. T is not needed and is not an input.
//
// Z^-1 is computed as Z^(p-2) by left-to-right square-and-multiply. All
// products run on one bit-serial, interleaved, MSB-first modular multiplier.
// The operation sequence never depends on the data, so the block is constant
// time.
//
// Ports
//   clk        in   1     clock, all logic on posedge
//   rst_n      in   1     asynchronous active-low reset
//   en         in   1     start strobe, sampled only while idle
//   x1,y1,z1   in   N     extended X/Y/Z, each < p
//   enc        out  N+1   compressed point {x_lsb, y}; held until the next result
//   inv_err    out  1     sampled Z was 0 (valid while data_rdy=1)
//   busy       out  1     operation in flight (the cycle after accept .. DONE)
//   data_rdy   out  1     level, enc/inv_err valid; cleared when en is accepted
//   fsm_state  out  3     current top-level FSM state (debug observation)
//
// Handshake: en is a one-cycle start request. It is accepted only on a posedge
// where the FSM is in IDLE; any en seen while busy (including the DONE cycle)
// is dropped, and the inputs are not re-sampled. data_rdy rises exactly
// 508*(N+1)+2 cycles after the accepting edge. It then stays high until the
// next accepted en.
// -----------------------------------------------------------------------------
module point_compress #(
  parameter int N = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] x1,
  input  logic [N-1:0] y1,
  input  logic [N-1:0] z1,
  output logic [N:0]   enc,
  output logic         inv_err,
  output logic         busy,
  output logic         data_rdy,
  output logic [2:0]   fsm_state
);

  localparam logic [N-1:0] P       = {N{1'b1}} - N'(18);   // 2^255 - 19
  localparam logic [N+1:0] P_EXT   = {2'b00, P};
  localparam logic [7:0]   CNT_TOP = 8'(N - 1);
  localparam logic [7:0]   STEP_TOP = 8'd253;              // first exponent bit below the MSB

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INV  = 3'd1,
    S_MULX = 3'd2,
    S_MULY = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Multiplier phase. M_ARM is a single cycle that follows capture. It keeps
  // the start-to-result latency at exactly 508*(N+1)+2 cycles.
  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_ARM  = 2'd1,
    M_LOAD = 2'd2,
    M_RUN  = 2'd3
  } mphase_t;

  state_t       state, state_nxt;
  mphase_t      mphase;

  logic [N-1:0] xr, yr, zr;        // captured operands
  logic [N-1:0] acc;               // exponentiation accumulator, ends as Z^-1
  logic [N-1:0] ma, mb;            // multiplier operands
  logic [N-1:0] macc;              // multiplier partial result, always < p
  logic [N-1:0] xa, ya;            // affine x and y
  logic [7:0]   cnt;               // multiplier bit index, N-1 down to 0
  logic [7:0]   step;              // exponent bit index, 253 down to 0
  logic         sq_phase;          // 0: squaring for this bit, 1: multiply by Z

  // ---------------------------------------------------------------------------
  // Multiplier iteration: acc = 2*acc + (b[i] ? a : 0). The sum is below 3p,
  // so two conditional subtractions bring it back below p.
  // ---------------------------------------------------------------------------
  logic [N+1:0] t0, t1, t2;
  logic [N-1:0] mul_res;

  always_comb begin
    t0      = {1'b0, macc, 1'b0} + (mb[cnt] ? {2'b00, ma} : '0);
    t1      = (t0 >= P_EXT) ? (t0 - P_EXT) : t0;
    t2      = (t1 >= P_EXT) ? (t1 - P_EXT) : t1;
    mul_res = t2[N-1:0];
  end

  // Exponent e = p-2 = 2^255-21. Bits 254..5 are all ones and e[4:0] = 01011.
  // Bit 254 is covered by initialising acc to Z.
  logic e_bit;
  always_comb begin
    case (step)
      8'd4:    e_bit = 1'b0;
      8'd3:    e_bit = 1'b1;
      8'd2:    e_bit = 1'b0;
      8'd1:    e_bit = 1'b1;
      8'd0:    e_bit = 1'b1;
      default: e_bit = 1'b1;
    endcase
  end

  logic mul_last;   // last iteration of the current multiply
  logic op_final;   // the finishing op is the last one for this exponent bit
  logic inv_done;   // Z^-1 complete this cycle

  always_comb begin
    mul_last = (mphase == M_RUN) && (cnt == 8'd0);
    op_final = sq_phase || !e_bit;
    inv_done = (state == S_INV) && mul_last && (step == 8'd0) && op_final;
  end

  // Operand selection for the next LOAD.
  logic [N-1:0] op_a, op_b;
  always_comb begin
    op_a = acc;
    op_b = acc;
    case (state)
      S_INV:   begin op_a = acc; op_b = sq_phase ? zr : acc; end
      S_MULX:  begin op_a = xr;  op_b = acc;                 end
      S_MULY:  begin op_a = yr;  op_b = acc;                 end
      default: begin op_a = acc; op_b = acc;                 end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (en)       state_nxt = S_INV;
      S_INV:   if (inv_done) state_nxt = S_MULX;
      S_MULX:  if (mul_last) state_nxt = S_MULY;
      S_MULY:  if (mul_last) state_nxt = S_DONE;
      S_DONE:                state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy      = (state != S_IDLE);
    fsm_state = state;
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mphase   <= M_IDLE;
      xr       <= '0;
      yr       <= '0;
      zr       <= '0;
      acc      <= '0;
      ma       <= '0;
      mb       <= '0;
      macc     <= '0;
      xa       <= '0;
      ya       <= '0;
      cnt      <= '0;
      step     <= '0;
      sq_phase <= 1'b0;
      enc      <= '0;
      inv_err  <= 1'b0;
      data_rdy <= 1'b0;
    end else begin
      if (state == S_IDLE && en) begin
        xr       <= x1;
        yr       <= y1;
        zr       <= z1;
        acc      <= z1;
        step     <= STEP_TOP;
        sq_phase <= 1'b0;
        mphase   <= M_ARM;
        data_rdy <= 1'b0;
      end

      case (mphase)
        M_ARM: mphase <= M_LOAD;
        M_LOAD: begin
          ma     <= op_a;
          mb     <= op_b;
          macc   <= '0;
          cnt    <= CNT_TOP;
          mphase <= M_RUN;
        end
        M_RUN: begin
          macc <= mul_res;
          cnt  <= cnt - 8'd1;
          if (cnt == 8'd0) begin
            case (state)
              S_INV: begin
                acc    <= mul_res;
                mphase <= M_LOAD;
                if (!op_final) begin
                  sq_phase <= 1'b1;
                end else begin
                  sq_phase <= 1'b0;
                  if (step != 8'd0) step <= step - 8'd1;
                end
              end
              S_MULX: begin
                xa     <= mul_res;
                mphase <= M_LOAD;
              end
              S_MULY: begin
                ya     <= mul_res;
                mphase <= M_IDLE;
              end
              default: mphase <= M_IDLE;
            endcase
          end
        end
        default: ;
      endcase

      // Z = 0 gives Z^-1 = 0 through the same sequence, so x = y = 0.
      if (state == S_DONE) begin
        enc      <= {xa[0], ya};
        inv_err  <= (zr == '0);
        data_rdy <= 1'b1;
      end
    end
  end

endmodule
